// File: rtl/serial_comparator_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serial_comparator_ctrl                                     |
// | Description : MSB-first bit-serial magnitude compare sequencer driving   |
// |               an external 1-bit comparator slice, with early exit.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module serial_comparator_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cmp_en,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_g,
  input  logic             cmp_l,
  input  logic             cmp_e,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic             err
);

  localparam int                c_IDX_W   = $clog2(WIDTH);
  localparam logic [c_IDX_W-1:0] c_IDX_MSB = c_IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state, w_state_next;
  logic [c_IDX_W-1:0] r_idx, w_idx_next;
  logic [WIDTH-1:0]   r_a, w_a_next;
  logic [WIDTH-1:0]   r_b, w_b_next;
  logic               r_gt, w_gt_next;
  logic               r_lt, w_lt_next;
  logic               r_eq, w_eq_next;
  logic               r_err, w_err_next;
  logic               r_busy, r_done;

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_gt_next    = r_gt;
    w_lt_next    = r_lt;
    w_eq_next    = r_eq;
    w_err_next   = r_err;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_a_next     = a;
          w_b_next     = b;
          w_idx_next   = c_IDX_MSB;
          w_gt_next    = 1'b0;
          w_lt_next    = 1'b0;
          w_eq_next    = 1'b0;
          w_err_next   = 1'b0;
          w_state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        case ({cmp_g, cmp_l, cmp_e})
          3'b100: begin
            w_gt_next    = 1'b1;
            w_state_next = S_DONE;
          end
          3'b010: begin
            w_lt_next    = 1'b1;
            w_state_next = S_DONE;
          end
          3'b001: begin
            if (r_idx == '0) begin
              w_eq_next    = 1'b1;
              w_state_next = S_DONE;
            end else begin
              w_idx_next = r_idx - c_IDX_W'(1);
            end
          end
          default: begin
            // Comparator produced a non-one-hot answer: abort with no verdict.
            w_err_next   = 1'b1;
            w_gt_next    = 1'b0;
            w_lt_next    = 1'b0;
            w_eq_next    = 1'b0;
            w_state_next = S_DONE;
          end
        endcase
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= c_IDX_MSB;
      r_a     <= '0;
      r_b     <= '0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
      r_eq    <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_gt    <= w_gt_next;
      r_lt    <= w_lt_next;
      r_eq    <= w_eq_next;
      r_err   <= w_err_next;
      r_busy  <= (w_state_next == S_SCAN);
      // The done pulse trails the DONE state by one registered cycle.
      r_done  <= (r_state == S_DONE);
    end
  end

  assign cmp_en = r_busy;
  assign busy   = r_busy;
  assign done   = r_done;
  assign gt     = r_gt;
  assign lt     = r_lt;
  assign eq     = r_eq;
  assign err    = r_err;
  assign cmp_a  = (r_state == S_SCAN) ? r_a[r_idx] : 1'b0;
  assign cmp_b  = (r_state == S_SCAN) ? r_b[r_idx] : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_serial_comparator_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_serial_comparator_ctrl                                  |
// | Description : Self-checking bench with a 1-bit comparator model and a    |
// |               result/latency scoreboard.                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_serial_comparator_ctrl;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic cmp_en, cmp_a, cmp_b, cmp_g, cmp_l, cmp_e;
  logic busy, done, gt, lt, eq, err;

  logic inj_en = 1'b0;
  int   slice_cnt = 0;
  logic m_bad;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic gt, lt, eq, err;
    int   lat;
    int   nsl;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  serial_comparator_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .cmp_en(cmp_en), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .cmp_g(cmp_g), .cmp_l(cmp_l), .cmp_e(cmp_e),
    .busy(busy), .done(done), .gt(gt), .lt(lt), .eq(eq), .err(err)
  );

  // Comparator slice model; the fault forces G and L together on the 3rd slice.
  always @(posedge clk) slice_cnt <= cmp_en ? slice_cnt + 1 : 0;
  assign m_bad = inj_en && (slice_cnt == 2);
  assign cmp_g = m_bad ? 1'b1 : (cmp_a & ~cmp_b);
  assign cmp_l = m_bad ? 1'b1 : (~cmp_a & cmp_b);
  assign cmp_e = m_bad ? 1'b0 : (cmp_a == cmp_b);

  function automatic exp_t make_exp(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input bit inj);
    exp_t e;
    int k;
    k = -1;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (k < 0 && ta[i] != tb_[i]) k = i;
    if (inj) begin
      e.gt = 0; e.lt = 0; e.eq = 0; e.err = 1; e.lat = 4; e.nsl = 3;
    end else begin
      e.gt  = (ta > tb_);
      e.lt  = (ta < tb_);
      e.eq  = (ta == tb_);
      e.err = 0;
      e.lat = (k < 0) ? WIDTH + 1 : WIDTH - k + 1;
      e.nsl = (k < 0) ? WIDTH : WIDTH - k;
    end
    return e;
  endfunction

  // One full compare: start at edge 0, walk the slices, check the done cycle.
  task automatic run_cmp(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input bit inj, input int restart_at);
    exp_t e, got;
    int   slc, ndone, done_edge;
    e = make_exp(ta, tb_, inj);
    sbq.push_back(e);
    slc = 0; ndone = 0; done_edge = -1;
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1; inj_en = inj;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom);
      end
      if (n == restart_at) begin
        start = 1'b1; a = 8'hFF; b = 8'h00;
      end
      if (n == restart_at + 1) start = 1'b0;
      if (cmp_en) begin
        n_cmp++;
        if (slc >= WIDTH || cmp_a !== ta[WIDTH-1-slc] || cmp_b !== tb_[WIDTH-1-slc]) begin
          n_bad++;
          $display("FAIL %s slice%0d: got a/b=%b%b expected a/b=%b%b", name, slc, cmp_a, cmp_b,
                   (slc < WIDTH) ? ta[WIDTH-1-slc] : 1'bx, (slc < WIDTH) ? tb_[WIDTH-1-slc] : 1'bx);
        end
        slc++;
      end
      if (done) begin
        ndone++;
        if (done_edge < 0) begin
          done_edge = n - 1;
          got = sbq.pop_front();
          n_cmp++;
          if (done_edge !== got.lat) begin
            n_bad++;
            $display("FAIL %s latency: got done after edge %0d expected %0d", name, done_edge, got.lat);
          end
          n_cmp++;
          if ({gt, lt, eq, err} !== {got.gt, got.lt, got.eq, got.err}) begin
            n_bad++;
            $display("FAIL %s result: got gt/lt/eq/err=%b%b%b%b expected %b%b%b%b", name,
                     gt, lt, eq, err, got.gt, got.lt, got.eq, got.err);
          end
          n_cmp++;
          if (slc !== got.nsl || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s slices: got %0d busy=%b expected %0d busy=0", name, slc, busy, got.nsl);
          end
        end
      end
      if (done_edge >= 0 && n - 1 >= done_edge + 3) break;
    end
    inj_en = 1'b0;
    n_cmp++;
    if (ndone !== 1) begin
      n_bad++;
      $display("FAIL %s done_count: got %0d expected 1", name, ndone);
      if (done_edge < 0) void'(sbq.pop_front());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({cmp_en, cmp_a, cmp_b, busy, done, gt, lt, eq, err} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected 000000000",
               {cmp_en, cmp_a, cmp_b, busy, done, gt, lt, eq, err});
    end
    rst = 1'b0;
  endtask

  task automatic test_equal();       run_cmp("equal_A5",   8'hA5, 8'hA5, 0, -1); endtask
  task automatic test_msb_gt();      run_cmp("msb_gt",     8'h80, 8'h7F, 0, -1); endtask
  task automatic test_lsb_lt();      run_cmp("lsb_lt",     8'h3C, 8'h3D, 0, -1); endtask
  task automatic test_ignore_start(); run_cmp("ign_start", 8'h3C, 8'h3D, 0, 3);  endtask
  task automatic test_err();
    run_cmp("err_inject", 8'hA5, 8'hA5, 1, -1);
    run_cmp("err_clear",  8'h5A, 8'h4A, 0, -1);
  endtask

  task automatic test_mid_reset();
    int ndone;
    ndone = 0;
    @(negedge clk);
    a = 8'hA5; b = 8'hA5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({cmp_en, cmp_a, cmp_b, busy, done, gt, lt, eq, err} !== 9'b0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got %b expected 000000000",
               {cmp_en, cmp_a, cmp_b, busy, done, gt, lt, eq, err});
    end
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (n == 2) rst = 1'b0;
      if (done) ndone++;
    end
    n_cmp++;
    if (ndone !== 0) begin
      n_bad++;
      $display("FAIL midreset_nodone: got %0d done pulses expected 0", ndone);
    end
    run_cmp("post_reset", 8'h01, 8'h00, 0, -1);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   de[$];
    sbq.push_back(make_exp(8'h80, 8'h7F, 0));
    sbq.push_back(make_exp(8'h80, 8'h7F, 0));
    @(negedge clk);
    a = 8'h80; b = 8'h7F; start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 6) start = 1'b0;
      if (done) begin
        de.push_back(n - 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          n_cmp++;
          if ({gt, lt, eq, err} !== {e.gt, e.lt, e.eq, e.err}) begin
            n_bad++;
            $display("FAIL b2b result: got %b%b%b%b expected %b%b%b%b", gt, lt, eq, err, e.gt, e.lt, e.eq, e.err);
          end
        end
      end
    end
    n_cmp++;
    if (de.size() !== 2 || de[0] !== 2 || de[1] !== 5) begin
      n_bad++;
      $display("FAIL b2b done_edges: got count=%0d first=%0d second=%0d expected 2/2/5",
               de.size(), (de.size() > 0) ? de[0] : -1, (de.size() > 1) ? de[1] : -1);
    end
    sbq.delete();
  endtask

  initial begin
    test_reset();
    test_equal();
    test_msb_gt();
    test_lsb_lt();
    test_ignore_start();
    test_err();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
